// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_nibble_adder.sv
// Purpose: 4-bit adder slice with carry in/out.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module nibble_adder (
    output logic [3:0] sum,
    output logic       cout,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       cin
);

    logic [4:0] total;

    assign total = {1'b0, in1} + {1'b0, in2} + {4'b0000, cin};
    assign sum   = total[3:0];
    assign cout  = total[4];

endmodule

// File: rtl/serial_add_ctrl.sv
// Purpose: WIDTH-bit add run one nibble per cycle through a single slice; SERIAL_ADD_SUB_EN adds subtract.
// Latency: result valid NIB+1 cycles after the accept edge.
// Backpressure: result held in DONE until res_ready; start_ready low whenever busy, no queueing.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             op,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               res_valid_q, res_valid_d;
    logic               start_ready_q, start_ready_d;
    logic               busy_q, busy_d;
`ifdef SERIAL_ADD_SUB_EN
    logic               op_q, op_d;
`endif

    logic [NIB_W-1:0]   slice_in1;
    logic [NIB_W-1:0]   slice_in2;
    logic [NIB_W-1:0]   slice_sum;
    logic               slice_cout;

    assign slice_in1 = a_q[NIB_W*idx_q +: NIB_W];
    assign slice_in2 = b_q[NIB_W*idx_q +: NIB_W];

    nibble_adder u_slice (
        .sum  (slice_sum),
        .cout (slice_cout),
        .in1  (slice_in1),
        .in2  (slice_in2),
        .cin  (carry_q)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        res_valid_d = res_valid_q;
`ifdef SERIAL_ADD_SUB_EN
        op_d        = op_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_valid && start_ready_q) begin
                    a_d   = a;
                    idx_d = '0;
                    sum_d = '0;
`ifdef SERIAL_ADD_SUB_EN
                    op_d    = op;
                    // Two's-complement subtract: invert B, carry seeds the +1.
                    b_d     = op ? ~b : b;
                    carry_d = op ? 1'b1 : cin;
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[NIB_W*idx_q +: NIB_W] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                // First DONE cycle settles the result; valid rises on the next edge.
                if (!res_valid_q) begin
                    res_valid_d = 1'b1;
                end else if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
            end
        endcase
        start_ready_d = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            sum_q         <= '0;
            idx_q         <= '0;
            carry_q       <= 1'b0;
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            op_q          <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            sum_q         <= sum_d;
            idx_q         <= idx_d;
            carry_q       <= carry_d;
            res_valid_q   <= res_valid_d;
            start_ready_q <= start_ready_d;
            busy_q        <= busy_d;
`ifdef SERIAL_ADD_SUB_EN
            op_q          <= op_d;
`endif
        end
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign sum         = sum_q;
    assign cout        = carry_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl; subtract vectors run when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

    localparam int WIDTH = 16;
    localparam int LAT   = 5;

    logic             clk;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             op;
`endif
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int n_chk;
    int n_err;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
`ifdef SERIAL_ADD_SUB_EN
        .op          (op),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        chk({tag, "_res_valid"},   32'(res_valid),   32'd0);
        chk({tag, "_sum"},         32'(sum),         32'd0);
        chk({tag, "_cout"},        32'(cout),        32'd0);
        chk({tag, "_busy"},        32'(busy),        32'd0);
    endtask

    // Called right after the accept edge; counts edges until res_valid.
    task automatic wait_res(input string tag, input logic [15:0] es, input logic ec);
        int cnt;
        cnt = 0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_start_ready"}, 32'(start_ready), 32'd0);
        while (!res_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        chk({tag, "_latency"}, 32'(cnt), 32'(LAT));
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
    endtask

    task automatic consume(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(start_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                          input logic ic, input logic iop, input logic scramble,
                          input logic [15:0] es, input logic ec);
        a = ia;
        b = ib;
        cin = ic;
`ifdef SERIAL_ADD_SUB_EN
        op = iop;
`else
        if (iop) $error("FAIL %s: subtract vector in add-only build", tag);
`endif
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        if (scramble) begin
            a = 16'hAAAA;
            b = 16'h5555;
            cin = 1'b1;
        end
        wait_res(tag, es, ec);
        consume(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        logic [15:0] held_sum;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        start_valid = 1'b0;
        res_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        op = 1'b0;
`endif
        #12;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        run_op("add_basic",  16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h2345, 1'b0);
        run_op("ripple_max", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_op("cin_only",   16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0);
        run_op("all_ones",   16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b1);
        run_op("mid_change", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0);

        // Backpressure with a competing request held on the start port.
        a = 16'h1234;
        b = 16'h1111;
        cin = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        wait_res("bp_first", 16'h2345, 1'b0);
        held_sum = sum;
        a = 16'h0F0F;
        b = 16'h0101;
        start_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", 32'(res_valid), 32'd1);
            chk("bp_hold_sum", 32'(sum), 32'(held_sum));
            chk("bp_hold_cout", 32'(cout), 32'd0);
            chk("bp_hold_start_ready", 32'(start_ready), 32'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp_release_valid", 32'(res_valid), 32'd0);
        chk("bp_release_idle", 32'(busy), 32'd0);
        chk("bp_release_ready", 32'(start_ready), 32'd1);
        tick();
        start_valid = 1'b0;
        wait_res("bp_second", 16'h1010, 1'b0);
        consume("bp_second");

        // Abort after two RUN cycles.
        a = 16'h1234;
        b = 16'h1111;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | res_valid;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        chk("abort_idle_ready", 32'(start_ready), 32'd1);
        run_op("after_abort", 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub_borrow",    16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0);
        run_op("sub_no_borrow", 16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b1);
        run_op("add_after_sub", 16'h0007, 16'h0005, 1'b0, 1'b0, 1'b0, 16'h000C, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
